aes_key_expansion: RTL and testbench

//  AES-128 key schedule writer. Reads the 16-byte cipher key, expands it to 44 four-byte columns and writes

---
 rtl/aes_key_expansion_if.sv | 32 +++
 rtl/aes_key_expansion.sv | 113 +++++++++++
 tb/tb_aes_key_expansion.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_expansion_if.sv
// Block handshake plus key ROM, S-box ROM and round-key memory ports of the AES-128 key expansion.
// master = the expansion engine, slave = the surrounding memories/controller.
interface aes_key_expansion_if;
  logic       ap_start;
  logic       ap_done;
  logic       ap_idle;
  logic       ap_ready;
  logic [4:0] key_address0;
  logic       key_ce0;
  logic [31:0] key_q0;
  logic [7:0] sbox_address0;
  logic       sbox_ce0;
  logic [7:0] sbox_q0;
  logic [8:0] word1_address0;
  logic       word1_ce0;
  logic       word1_we0;
  logic [7:0] word1_d0;

  modport master (
    input  ap_start, key_q0, sbox_q0,
    output ap_done, ap_idle, ap_ready,
    output key_address0, key_ce0, sbox_address0, sbox_ce0,
    output word1_address0, word1_ce0, word1_we0, word1_d0
  );

  modport slave (
    output ap_start, key_q0, sbox_q0,
    input  ap_done, ap_idle, ap_ready,
    input  key_address0, key_ce0, sbox_address0, sbox_ce0,
    input  word1_address0, word1_ce0, word1_we0, word1_d0
  );
endinterface

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule writer: streams the cipher key in, expands it to 44 columns and writes every
// byte of the schedule once into the round-key memory at row*ROW_STRIDE + col.
module aes_key_expansion #(
  parameter int NK         = 4,
  parameter int NR         = 10,
  parameter int ROW_STRIDE = 120
) (
  input  logic ap_clk,
  input  logic ap_rst,
  aes_key_expansion_if.master bus
);
  localparam int NCOL = 4 * (NR + 1);
  localparam logic [4:0] LOAD_LAST = 5'(4 * NK);
  localparam logic [5:0] COL_LAST  = 6'(NCOL - 1);
  localparam logic [5:0] COL_FIRST = 6'(NK);

  typedef enum logic [2:0] {IDLE, LOAD, SUB, WR, DONE} state_t;

  state_t                 state;
  logic [4:0]             cnt;      // LOAD 0..16, SUB 0..4, WR row 0..3
  logic [5:0]             col;      // column j being produced
  logic [7:0]             rcon;
  logic [3:0][3:0][7:0]   win;      // win[0] = column j-4 .. win[3] = column j-1
  logic [3:0][7:0]        sub_col;  // SubWord(RotWord(temp)) ^ rcon
  logic [3:0][7:0]        temp;
  logic [3:0]             lk;
  logic                   key_hi_unused;

  assign lk            = cnt[3:0] - 4'd1;
  assign temp          = (col[1:0] == 2'd0) ? sub_col : win[3];
  assign key_hi_unused = ^bus.key_q0[31:8];

  function automatic logic [8:0] waddr(input logic [1:0] r, input logic [5:0] c);
    return 9'(r) * 9'(ROW_STRIDE) + 9'(c);
  endfunction

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      col     <= '0;
      rcon    <= 8'h01;
      win     <= '0;
      sub_col <= '0;
    end else begin
      case (state)
        IDLE: if (bus.ap_start) begin
          state <= LOAD;
          cnt   <= '0;
          col   <= COL_FIRST;
          rcon  <= 8'h01;
        end
        LOAD: begin
          if (cnt != 5'd0) win[lk[3:2]][lk[1:0]] <= bus.key_q0[7:0];
          if (cnt == LOAD_LAST) begin
            state <= SUB;
            cnt   <= '0;
          end else cnt <= cnt + 5'd1;
        end
        SUB: begin
          // first captured byte is S(temp[1]), the one that carries rcon
          if (cnt != 5'd0) sub_col[lk[1:0]] <= (cnt == 5'd1) ? (bus.sbox_q0 ^ rcon) : bus.sbox_q0;
          if (cnt == 5'd4) begin
            state <= WR;
            cnt   <= '0;
          end else cnt <= cnt + 5'd1;
        end
        WR: begin
          if (cnt == 5'd3) begin
            win <= {win[0] ^ temp, win[3], win[2], win[1]};
            if (col[1:0] == 2'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            cnt <= '0;
            if (col == COL_LAST) state <= DONE;
            else begin
              col   <= col + 6'd1;
              state <= (col[1:0] == 2'd3) ? SUB : WR;
            end
          end else cnt <= cnt + 5'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side strobes decode straight from registered state; key data passes through in the
  // cycle it returns from the ROM.
  always_comb begin
    bus.key_ce0        = (state == LOAD) && (cnt < LOAD_LAST);
    bus.key_address0   = cnt;
    bus.sbox_ce0       = (state == SUB) && (cnt < 5'd4);
    bus.sbox_address0  = win[3][cnt[1:0] + 2'd1];
    bus.word1_ce0      = 1'b0;
    bus.word1_we0      = 1'b0;
    bus.word1_address0 = '0;
    bus.word1_d0       = '0;
    if (state == LOAD && cnt != 5'd0) begin
      bus.word1_ce0      = 1'b1;
      bus.word1_we0      = 1'b1;
      bus.word1_address0 = waddr(lk[1:0], {4'd0, lk[3:2]});
      bus.word1_d0       = bus.key_q0[7:0];
    end else if (state == WR) begin
      bus.word1_ce0      = 1'b1;
      bus.word1_we0      = 1'b1;
      bus.word1_address0 = waddr(cnt[1:0], col);
      bus.word1_d0       = win[0][cnt[1:0]] ^ temp[cnt[1:0]];
    end
  end

  assign bus.ap_done  = (state == DONE);
  assign bus.ap_ready = (state == DONE);
  assign bus.ap_idle  = (state == IDLE) && !bus.ap_start;
endmodule

// File: tb/tb_aes_key_expansion.sv
// Randomized self-checking bench for aes_key_expansion against a textbook AES-128 key schedule
// built on an S-box derived from GF(2^8) inversion and the affine map.
module tb_aes_key_expansion;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  aes_key_expansion_if bus();

  aes_key_expansion dut (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus));

  always #5 ap_clk = ~ap_clk;

  int n_chk = 0, n_fail = 0;
  logic [7:0] key_mem [16];
  logic [7:0] sb [256];
  logic [7:0] w1 [480];
  int         wc [480];
  int         wr_total;
  logic [7:0] exp_w [44][4];
  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  int         done_q [$];
  int         idle_bad, rdy_bad;
  logic       kce230;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ROM models, one-cycle read latency; key upper bits carry noise that must be ignored
  always @(posedge ap_clk) begin
    if (bus.key_ce0)  bus.key_q0  <= {24'($urandom), key_mem[bus.key_address0[3:0]]};
    if (bus.sbox_ce0) bus.sbox_q0 <= sb[bus.sbox_address0];
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [127:0] k);
    for (int i = 0; i < 16; i++) key_mem[i] = k[127 - 8*i -: 8];
  endtask

  task automatic model();
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) exp_w[c][r] = key_mem[4*c + r];
    for (int j = 4; j < 44; j++) begin
      logic [7:0] t [4];
      for (int r = 0; r < 4; r++) t[r] = exp_w[j-1][r];
      if (j % 4 == 0) begin
        logic [7:0] t0 = t[0];
        t[0] = sb[t[1]] ^ rcon_tab[j/4 - 1];
        t[1] = sb[t[2]];
        t[2] = sb[t[3]];
        t[3] = sb[t0];
      end
      for (int r = 0; r < 4; r++) exp_w[j][r] = exp_w[j-4][r] ^ t[r];
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 480; a++) begin
      w1[a] = 8'h00;
      wc[a] = 0;
    end
    wr_total = 0;
    done_q.delete();
    idle_bad = 0;
    rdy_bad  = 0;
    kce230   = 1'b0;
  endtask

  task automatic sample();
    @(negedge ap_clk);
    if (bus.word1_ce0 && bus.word1_we0) begin
      wr_total++;
      if (bus.word1_address0 < 9'd480) begin
        w1[bus.word1_address0] = bus.word1_d0;
        wc[bus.word1_address0]++;
      end
    end
  endtask

  // cycles are counted from the edge that samples ap_start (cycle 0)
  task automatic observe(input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      sample();
      if (bus.ap_done) done_q.push_back(c);
      if (bus.ap_ready !== bus.ap_done) rdy_bad++;
      if (c <= 228 && bus.ap_idle) idle_bad++;
      if (c == 230) kce230 = bus.key_ce0;
    end
  endtask

  task automatic start_run(input logic hold);
    @(negedge ap_clk);
    bus.ap_start = 1'b1;
    @(posedge ap_clk);
    #1 bus.ap_start = hold;
  endtask

  task automatic check_mem(input string tag, input int mult);
    int bad = 0;
    model();
    for (int j = 0; j < 44; j++)
      for (int i = 0; i < 4; i++)
        chk($sformatf("%s_a%0d", tag, i*120 + j), w1[i*120 + j], exp_w[j][i]);
    for (int a = 0; a < 480; a++)
      if (wc[a] != (((a % 120) < 44) ? mult : 0)) bad++;
    chk({tag, "_addr_once"}, bad, 0);
    chk({tag, "_writes"}, wr_total, 176 * mult);
    for (int k = 0; k < 10; k++) begin
      int j = 4*k + 4;
      chk($sformatf("%s_rcon%0d", tag, k), w1[j] ^ w1[j-4] ^ sb[w1[120 + j - 1]], rcon_tab[k]);
    end
  endtask

  task automatic full_run(input string tag);
    clear_mem();
    start_run(1'b0);
    observe(1, 232);
    chk({tag, "_ndone"}, done_q.size(), 1);
    chk({tag, "_done_cyc"}, (done_q.size() > 0) ? done_q[0] : -1, 228);
    chk({tag, "_idle_low"}, idle_bad, 0);
    chk({tag, "_ready_eq_done"}, rdy_bad, 0);
    chk({tag, "_idle_end"}, bus.ap_idle, 1);
    check_mem(tag, 1);
  endtask

  initial begin
    int nwr;
    bus.ap_start = 1'b0;
    bus.key_q0   = '0;
    bus.sbox_q0  = '0;
    build_sbox();
    chk("sbox00", sb[0], 8'h63);
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_idle", bus.ap_idle, 1);
    chk("rst_done", bus.ap_done, 0);
    chk("rst_ready", bus.ap_ready, 0);
    chk("rst_we", {bus.word1_ce0, bus.word1_we0, bus.key_ce0, bus.sbox_ce0}, 0);
    ap_rst = 1'b0;

    set_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    full_run("fips");
    chk("fips_c4r0", w1[4], 8'ha0);   chk("fips_c4r1", w1[124], 8'hfa);
    chk("fips_c4r2", w1[244], 8'hfe); chk("fips_c4r3", w1[364], 8'h17);
    chk("fips_c43r0", w1[43], 8'hb6); chk("fips_c43r1", w1[163], 8'h63);
    chk("fips_c43r2", w1[283], 8'h0c); chk("fips_c43r3", w1[403], 8'ha6);

    set_key(128'h0);
    full_run("zero");
    chk("zero_c4r0", w1[4], 8'h62);   chk("zero_c4r1", w1[124], 8'h63);
    chk("zero_c4r2", w1[244], 8'h63); chk("zero_c4r3", w1[364], 8'h63);
    chk("zero_c43r0", w1[43], 8'h6f); chk("zero_c43r1", w1[163], 8'h8f);
    chk("zero_c43r2", w1[283], 8'h18); chk("zero_c43r3", w1[403], 8'h8e);

    for (int n = 0; n < 3; n++) begin
      set_key({$urandom, $urandom, $urandom, $urandom});
      full_run($sformatf("rnd%0d", n));
    end

    // reset lands mid-expansion: rst high during cycle 100
    clear_mem();
    set_key({$urandom, $urandom, $urandom, $urandom});
    start_run(1'b0);
    for (int c = 1; c <= 100; c++) sample();
    ap_rst = 1'b1;
    nwr = wr_total;
    sample();
    chk("midrst_idle", bus.ap_idle, 1);
    chk("midrst_done", bus.ap_done, 0);
    ap_rst = 1'b0;
    for (int c = 0; c < 10; c++) sample();
    chk("midrst_nowr", wr_total, nwr);
    set_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    full_run("postrst");
    chk("postrst_c43r3", w1[403], 8'ha6);

    // ap_start held through DONE: second run starts straight from the following IDLE cycle
    clear_mem();
    start_run(1'b1);
    observe(1, 300);
    bus.ap_start = 1'b0;
    observe(301, 465);
    chk("b2b_ndone", done_q.size(), 2);
    chk("b2b_done1", (done_q.size() > 0) ? done_q[0] : -1, 228);
    chk("b2b_done2", (done_q.size() > 1) ? done_q[1] : -1, 457);
    chk("b2b_kce230", kce230, 1);
    chk("b2b_ready_eq_done", rdy_bad, 0);
    check_mem("b2b", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
